// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------
// hazard_ctrl_pkg: shared types for the pipeline hazard controller. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

    localparam int ADDR_LINE_REG = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------
// fwd_unit: combinational EX operand forwarding selects. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module fwd_unit #(
    parameter int ADDR_LINE_REG = 5
) (
    input  logic [ADDR_LINE_REG-1:0] ex_rs,
    input  logic [ADDR_LINE_REG-1:0] ex_rt,
    input  logic [ADDR_LINE_REG-1:0] mem_rd,
    input  logic                     mem_reg_write,
    input  logic [ADDR_LINE_REG-1:0] wb_rd,
    input  logic                     wb_reg_write,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b
);
    import hazard_ctrl_pkg::*;

    // EX/MEM is younger than MEM/WB, so it wins; $zero is never a producer.
    function automatic fwd_sel_t pick(
        input logic [ADDR_LINE_REG-1:0] src,
        input logic [ADDR_LINE_REG-1:0] m_rd,
        input logic                     m_we,
        input logic [ADDR_LINE_REG-1:0] w_rd,
        input logic                     w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == src)) return FWD_MEM;
        if (w_we && (w_rd != '0) && (w_rd == src)) return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd_a = pick(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    assign fwd_b = pick(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------
// hazard_ctrl: stall, flush and forwarding control for the 5-stage MIPS core. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int ADDR_LINE_REG = 5,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [ADDR_LINE_REG-1:0] id_rs,
    input  logic [ADDR_LINE_REG-1:0] id_rt,
    input  logic                     id_uses_rt,
    input  logic [ADDR_LINE_REG-1:0] ex_rs,
    input  logic [ADDR_LINE_REG-1:0] ex_rt,
    input  logic [ADDR_LINE_REG-1:0] ex_rd,
    input  logic                     ex_mem_read,
    input  logic [ADDR_LINE_REG-1:0] mem_rd,
    input  logic                     mem_reg_write,
    input  logic [ADDR_LINE_REG-1:0] wb_rd,
    input  logic                     wb_reg_write,
    input  logic                     branch_taken,
    input  logic                     mem_busy,
    output logic                     hazard,
    output logic                     freeze,
    output logic                     bubble_id_ex,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);
    import hazard_ctrl_pkg::*;

    localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t          r_state;
    logic [REM_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;
    logic               w_load_use;

    fwd_unit #(
        .ADDR_LINE_REG (ADDR_LINE_REG)
    ) u_fwd_unit (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (w_fwd_a),
        .fwd_b         (w_fwd_b)
    );

    assign w_load_use = id_valid && ex_mem_read && (ex_rd != '0) &&
                        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // A released MEM_WAIT behaves exactly like RUN, so only FLUSH needs its own arm.
    always_comb begin
        hazard       = 1'b0;
        freeze       = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        if (reset) begin
            fwd_a = w_fwd_a;
            fwd_b = w_fwd_b;
            if (mem_busy) begin
                hazard = 1'b1;
                freeze = 1'b1;
            end else if (r_state == FLUSH) begin
                flush_if_id = 1'b1;
            end else if (branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (w_load_use) begin
                hazard       = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_remaining <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hazard && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_id_ex && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            case (r_state)
                FLUSH: begin
                    if (mem_busy) begin
                        r_state     <= MEM_WAIT;
                        r_remaining <= '0;
                    end else if (r_remaining == REM_W'(1)) begin
                        r_state     <= RUN;
                        r_remaining <= '0;
                    end else begin
                        r_remaining <= r_remaining - REM_W'(1);
                    end
                end
                default: begin
                    if (mem_busy) begin
                        r_state <= MEM_WAIT;
                    end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                        r_state     <= FLUSH;
                        r_remaining <= REM_W'(FLUSH_CYCLES - 1);
                    end else begin
                        r_state <= RUN;
                    end
                end
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------
// tb_hazard_ctrl: directed scenarios plus randomized run against a reference model. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
    logic          branch_taken, mem_busy;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          hazard, freeze, bubble_id_ex, flush_if_id, flush_id_ex;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [8:0]    got;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: IF/ID flush cycles still owed, and the two counters.
    int m_flush_left = 0;
    int m_stall      = 0;
    int m_flush      = 0;

    hazard_ctrl #(
        .ADDR_LINE_REG (AW),
        .FLUSH_CYCLES  (FC),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .hazard        (hazard),
        .freeze        (freeze),
        .bubble_id_ex  (bubble_id_ex),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    assign got = {hazard, freeze, bubble_id_ex, flush_if_id, flush_id_ex, fwd_a, fwd_b};

    function automatic logic [1:0] m_fwd(input int src);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == src) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == src) return 2'b01;
        return 2'b00;
    endfunction

    // Bits: hazard, freeze, bubble, flush_if_id, flush_id_ex, fwd_a[1:0], fwd_b[1:0]
    function automatic logic [8:0] model_out();
        logic [8:0] e;
        logic       lu;
        e = '0;
        if (!reset) return e;
        lu = id_valid && ex_mem_read && ex_rd != 0 &&
             (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        if (mem_busy)              e[8:7] = 2'b11;
        else if (m_flush_left > 0) e[5]   = 1'b1;
        else if (branch_taken)     e[5:4] = 2'b11;
        else if (lu)               begin e[8] = 1'b1; e[6] = 1'b1; end
        e[3:2] = m_fwd(int'(ex_rs));
        e[1:0] = m_fwd(int'(ex_rt));
        return e;
    endfunction

    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        e = model_out();
        if (!reset) begin
            m_flush_left = 0;
            m_stall      = 0;
            m_flush      = 0;
        end else begin
            if (e[8]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (e[4]) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            if (mem_busy)              m_flush_left = 0;
            else if (m_flush_left > 0) m_flush_left--;
            else if (branch_taken)     m_flush_left = FC - 1;
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_uses_rt = 0; ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
        branch_taken = 0; mem_busy = 0;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic set_load_use();
        ex_rd = 5; ex_mem_read = 1; id_rs = 5; id_valid = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        id_valid = 1; id_uses_rt = 1; ex_mem_read = 1; mem_reg_write = 1; wb_reg_write = 1;
        branch_taken = 1; mem_busy = 1;
        id_rs = 3; id_rt = 3; ex_rs = 3; ex_rt = 3; ex_rd = 3; mem_rd = 3; wb_rd = 3;
        #2;
        vectors++;
        if (got !== 9'b0) begin
            miscompares++; $display("FAIL reset_outputs: got %b expected %b", got, 9'b0);
        end
        tick();
        reset = 1;
        idle();
        #2;
        vectors++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            miscompares++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        vectors++;
        if (got !== 9'b0) begin
            miscompares++; $display("FAIL reset_idle: got %b expected %b", got, 9'b0);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #2;
        vectors++;
        if (got !== 9'b101_00_0000) begin
            miscompares++; $display("FAIL load_use_stall: got %b expected %b", got, 9'b101_00_0000);
        end
        tick();
        ex_rd = 0; ex_mem_read = 0;
        #2;
        vectors++;
        if (hazard !== 1'b0 || bubble_id_ex !== 1'b0) begin
            miscompares++; $display("FAIL load_use_release: got %b%b expected 00", hazard, bubble_id_ex);
        end
        vectors++;
        if (stall_cnt !== 4'd1) begin
            miscompares++; $display("FAIL load_use_count: got %0d expected 1", stall_cnt);
        end
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        ex_rs = 7; ex_rt = 3; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
        #2;
        vectors++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            miscompares++; $display("FAIL fwd_mem_priority: got %b/%b expected 10/00", fwd_a, fwd_b);
        end
        mem_rd = 0;
        #2;
        vectors++;
        if (fwd_a !== 2'b01) begin
            miscompares++; $display("FAIL fwd_wb: got %b expected 01", fwd_a);
        end
        ex_rs = 0; wb_rd = 0; ex_rt = 0;
        #2;
        vectors++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            miscompares++; $display("FAIL fwd_zero_reg: got %b/%b expected 00/00", fwd_a, fwd_b);
        end
        ex_rt = 9; wb_rd = 9; mem_rd = 4;
        #2;
        vectors++;
        if (fwd_b !== 2'b01) begin
            miscompares++; $display("FAIL fwd_b_wb: got %b expected 01", fwd_b);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1;
        #2;
        vectors++;
        if (got !== 9'b000_11_0000) begin
            miscompares++; $display("FAIL branch_first: got %b expected %b", got, 9'b000_11_0000);
        end
        tick();
        branch_taken = 0;
        #2;
        vectors++;
        if (got !== 9'b000_10_0000) begin
            miscompares++; $display("FAIL branch_second: got %b expected %b", got, 9'b000_10_0000);
        end
        tick();
        #2;
        vectors++;
        if (got !== 9'b0 || flush_cnt !== 4'd1) begin
            miscompares++; $display("FAIL branch_done: got %b cnt %0d expected 0 cnt 1", got, flush_cnt);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_load_use();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if (got !== 9'b110_00_0000) begin
                miscompares++; $display("FAIL mem_wait_busy cycle %0d: got %b expected %b", i, got, 9'b110_00_0000);
            end
            tick();
        end
        mem_busy = 0;
        #2;
        vectors++;
        if (got !== 9'b101_00_0000) begin
            miscompares++; $display("FAIL mem_wait_release: got %b expected %b", got, 9'b101_00_0000);
        end
        tick();
        idle();
        #2;
        vectors++;
        if (stall_cnt !== 4'd4) begin
            miscompares++; $display("FAIL mem_wait_count: got %0d expected 4", stall_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_load_use();
        branch_taken = 1;
        #2;
        vectors++;
        if (got !== 9'b000_11_0000) begin
            miscompares++; $display("FAIL branch_over_load_use: got %b expected %b", got, 9'b000_11_0000);
        end
        tick();
        branch_taken = 0; id_valid = 0;
        reset = 0;
        #2;
        vectors++;
        if (got !== 9'b0) begin
            miscompares++; $display("FAIL reset_mid_flush: got %b expected %b", got, 9'b0);
        end
        tick();
        reset = 1;
        #2;
        vectors++;
        if (got !== 9'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            miscompares++; $display("FAIL after_reset: got %b cnt %0d/%0d expected 0 cnt 0/0", got, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1;
        repeat (20) tick();
        mem_busy = 0;
        #2;
        vectors++;
        if (stall_cnt !== 4'(SAT) || flush_cnt !== 4'd0) begin
            miscompares++; $display("FAIL stall_saturate: got %0d/%0d expected %0d/0", stall_cnt, flush_cnt, SAT);
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) != 0);
            id_valid      = $urandom_range(0, 3) != 0;
            id_uses_rt    = $urandom_range(0, 1) != 0;
            ex_mem_read   = $urandom_range(0, 1) != 0;
            mem_reg_write = $urandom_range(0, 1) != 0;
            wb_reg_write  = $urandom_range(0, 1) != 0;
            branch_taken  = $urandom_range(0, 5) == 0;
            mem_busy      = $urandom_range(0, 4) == 0;
            id_rs  = AW'($urandom_range(0, 3));
            id_rt  = AW'($urandom_range(0, 3));
            ex_rs  = AW'($urandom_range(0, 3));
            ex_rt  = AW'($urandom_range(0, 3));
            ex_rd  = AW'($urandom_range(0, 3));
            mem_rd = AW'($urandom_range(0, 3));
            wb_rd  = AW'($urandom_range(0, 3));
            #2;
            e = model_out();
            vectors++;
            if (got !== e) begin
                miscompares++; $display("FAIL random_out cycle %0d: got %b expected %b", i, got, e);
            end
            vectors++;
            if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin
                miscompares++;
                $display("FAIL random_cnt cycle %0d: got %0d/%0d expected %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1;
        #1;
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_mem_wait();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
